// File: rtl/px_adc_pkg.sv
// Shared types and defaults for the pixel-column ADC serial front-end.
package px_adc_pkg;

    localparam int unsigned PX_ADC_NBITS  = 16;
    localparam int unsigned PX_ADC_DATA_W = 12;
    localparam int unsigned PX_ADC_NCH    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE,
        ST_QUIET
    } px_adc_state_e;

    // Cycles from the start request to the sample_valid strobe.
    function automatic int unsigned px_adc_latency(input int unsigned clk_div,
                                                   input int unsigned nbits);
        return clk_div * (2 * nbits + 1) + 2;
    endfunction

endpackage

// File: rtl/px_adc_shreg.sv
// One ADC channel: MSB-first frame shift register with sample slice and leading-bit check.
module px_adc_shreg
    import px_adc_pkg::*;
#(
    parameter int unsigned NBITS  = PX_ADC_NBITS,
    parameter int unsigned DATA_W = PX_ADC_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic              din_i,
    output logic [DATA_W-1:0] data_o,
    output logic              lead_err_o
);

    logic [NBITS-1:0] shreg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else if (shift_en_i) begin
            shreg_q <= {shreg_q[NBITS-2:0], din_i};
        end
    end

    assign data_o = shreg_q[DATA_W-1:0];

    // Leading bits exist only when the frame is longer than the sample.
    generate
        if (NBITS > DATA_W) begin : g_lead
            assign lead_err_o = |shreg_q[NBITS-1:DATA_W];
        end else begin : g_nolead
            assign lead_err_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/px_adc_reader.sv
// Drives CS/SCLK for four parallel pixel-column ADCs and presents one sample set per start.
module px_adc_reader
    import px_adc_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned NBITS     = PX_ADC_NBITS,
    parameter int unsigned DATA_W    = PX_ADC_DATA_W,
    parameter int unsigned QUIET_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              px0_adc_din,
    input  logic              px1_adc_din,
    input  logic              px2_adc_din,
    input  logic              px3_adc_din,
    output logic              px_adc_cs,
    output logic              px_adc_sclk,
    output logic [DATA_W-1:0] sample0,
    output logic [DATA_W-1:0] sample1,
    output logic [DATA_W-1:0] sample2,
    output logic [DATA_W-1:0] sample3,
    output logic              sample_valid,
    output logic [3:0]        frame_err,
    output logic              busy,
    output logic              start_drop
);

    localparam int unsigned NCH    = PX_ADC_NCH;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = $clog2(NBITS + 1);
    localparam int unsigned QCNT_W = $clog2(QUIET_CYC + 1);

    px_adc_state_e      state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [QCNT_W-1:0]  qcnt_q, qcnt_d;
    logic               cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic               busy_q, busy_d;
    logic               drop_q, drop_d;
    logic               valid_q, valid_d;
    logic               shift_en_c;
    logic               div_last_c, bit_last_c, q_last_c;
    logic [NCH-1:0]     din_c;
    logic [NCH-1:0]     lead_c;
    logic [DATA_W-1:0]  data_c   [NCH];
    logic [DATA_W-1:0]  sample_q [NCH];
    logic [NCH-1:0]     ferr_q;

    assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_last_c = (bit_q == BIT_W'(NBITS));
    assign q_last_c   = (qcnt_q == QCNT_W'(QUIET_CYC - 1));
    assign din_c      = {px3_adc_din, px2_adc_din, px1_adc_din, px0_adc_din};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SETUP;
            ST_SETUP: if (div_last_c) state_d = ST_SHIFT;
            ST_SHIFT: if (div_last_c && sclk_q && bit_last_c) state_d = ST_DONE;
            ST_DONE:  state_d = ST_QUIET;
            ST_QUIET: if (q_last_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SCLK phases: CLK_DIV cycles low then CLK_DIV high; din is taken on the low->high edge.
    always_comb begin
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        div_d      = div_q;
        bit_d      = bit_q;
        qcnt_d     = qcnt_q;
        valid_d    = 1'b0;
        drop_d     = start && (state_q != ST_IDLE);
        shift_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cs_d   = 1'b0;
                    busy_d = 1'b1;
                    div_d  = '0;
                    bit_d  = '0;
                end
            end
            ST_SETUP: begin
                if (div_last_c) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_last_c) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d     = 1'b1;
                        shift_en_c = 1'b1;
                        bit_d      = bit_q + BIT_W'(1);
                    end else if (!bit_last_c) begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                cs_d    = 1'b1;
                valid_d = 1'b1;
                qcnt_d  = '0;
            end
            ST_QUIET: begin
                if (q_last_c) begin
                    busy_d = 1'b0;
                end else begin
                    qcnt_d = qcnt_q + QCNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            bit_q   <= '0;
            qcnt_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= '0;
            for (int i = 0; i < NCH; i++) sample_q[i] <= '0;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            qcnt_q  <= qcnt_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            if (state_q == ST_DONE) begin
                ferr_q <= lead_c;
                for (int i = 0; i < NCH; i++) sample_q[i] <= data_c[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            px_adc_shreg #(
                .NBITS  (NBITS),
                .DATA_W (DATA_W)
            ) u_shreg (
                .clk        (clk),
                .reset      (reset),
                .shift_en_i (shift_en_c),
                .din_i      (din_c[g]),
                .data_o     (data_c[g]),
                .lead_err_o (lead_c[g])
            );
        end
    endgenerate

    assign px_adc_cs    = cs_q;
    assign px_adc_sclk  = sclk_q;
    assign sample0      = sample_q[0];
    assign sample1      = sample_q[1];
    assign sample2      = sample_q[2];
    assign sample3      = sample_q[3];
    assign sample_valid = valid_q;
    assign frame_err    = ferr_q;
    assign busy         = busy_q;
    assign start_drop   = drop_q;

endmodule

// File: doc/px_adc_reader.md
Name: px_adc_reader

Overview:
- Serial front-end for the four pixel-column ADCs (12-bit, SPI-style, 16-clock frame).
- Placed directly upstream of the imaging capture/FIFO logic.
- On each start pulse from the imaging sequencer: drives the shared chip-select and SCLK, shifts all four data lines in parallel, and presents four 12-bit samples with a one-cycle valid strobe.
- The downstream capture state machine writes these samples into the camera FIFO.

Parameters:
- CLK_DIV, 2: SCLK half-period in clk cycles. Legal range is 1..255.
- NBITS, 16: SCLK cycles per conversion frame.
- DATA_W, 12: sample width. It is the last DATA_W bits of the frame, MSB first.
- QUIET_CYC, 4: clk cycles with CS high between frames (ADC t_quiet).

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to convert. Ignored unless idle.
- px0_adc_din  in  1  ADC channel 0 serial data.
- px1_adc_din  in  1  ADC channel 1 serial data.
- px2_adc_din  in  1  ADC channel 2 serial data.
- px3_adc_din  in  1  ADC channel 3 serial data.
- px_adc_cs  out  1  shared ADC chip select, active-low.
- px_adc_sclk  out  1  shared ADC serial clock. Idles high.
- sample0  out  DATA_W  channel 0 result.
- sample1  out  DATA_W  channel 1 result.
- sample2  out  DATA_W  channel 2 result.
- sample3  out  DATA_W  channel 3 result.
- sample_valid  out  1  one-cycle strobe; samples are valid in the same cycle.
- frame_err  out  4  per-channel flag: a leading (NBITS-DATA_W) bit was non-zero in the last frame.
- busy  out  1  high from the accepted start through the end of QUIET.
- start_drop  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- All outputs are registered.
- Reset values: px_adc_cs=1, px_adc_sclk=1, sample0..3=0, sample_valid=0, frame_err=0, busy=0, start_drop=0. State is IDLE.
- FSM states: IDLE, SETUP, SHIFT, DONE, QUIET.
- IDLE:
  - start=1 -> SETUP.
  - On that edge: px_adc_cs<=0, busy<=1, div/bit counters cleared.
- SETUP: holds CS low with SCLK high for CLK_DIV cycles, then -> SHIFT with px_adc_sclk<=0.
- SHIFT:
  - Each bit is CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high.
  - din for all four channels is sampled on the clk edge that drives SCLK 0->1, into an NBITS shift register, MSB first.
  - After NBITS rising SCLK edges, the next low phase is not started: SCLK stays high -> DONE.
- DONE, one cycle:
  - px_adc_cs<=1.
  - sampleN<=shreg[DATA_W-1:0].
  - frame_err[N]<=|shreg[NBITS-1:DATA_W].
  - sample_valid<=1.
  - -> QUIET.
- QUIET: QUIET_CYC cycles with CS high, then busy<=0 -> IDLE.
- Latency: sample_valid is high exactly CLK_DIV*(2*NBITS+1)+2 cycles after the start edge. With defaults this is 68.
- Throughput: a new start is accepted on the first cycle busy=0. Minimum start-to-start spacing is latency+QUIET_CYC.
- start while busy: no effect on the FSM; start_drop pulses for 1 cycle.
- start on the cycle busy falls: busy is already 0, so start is accepted.
- sample0..3 hold their value until the next DONE. sample_valid is exactly 1 cycle.
- Reset asserted mid-frame: immediate return to reset values. CS deasserts asynchronously, no valid is issued, and partial data is discarded.
- When NBITS==DATA_W, frame_err is constant 0.

Decomposition:
- Shared package px_adc_pkg:
  - FSM state enum.
  - Default constants PX_ADC_NBITS=16, PX_ADC_DATA_W=12, PX_ADC_NCH=4.
  - Latency helper function.
- Sub-module px_adc_shreg: per-channel NBITS shift register with sample-enable.
  - Exposes the data slice and the leading-bit OR.
  - Instantiated 4x.
- The top level holds the FSM, the SCLK divider and the bit counter.

Test Plan:
- Reset then idle (200 cycles, no start) -> px_adc_cs=1, px_adc_sclk=1, busy=0, no sample_valid.
- Defaults; ADC model drives 0x0ABC/0x0123/0x0FFF/0x0000 on ch0..3; pulse start -> 16 SCLK falling/rising pairs, each half-period 2 cycles. sample_valid at +68 cycles; sample0..3 = 0xABC/0x123/0xFFF/0x000; frame_err=0; busy drops at +72.
- ch2 model drives 0x8FFF -> sample2=0xFFF, frame_err=4'b0100.
- start at +10 and +40 after an accepted start -> two start_drop pulses; exactly one sample_valid.
- Back-to-back: start held high continuously -> frames every 72 cycles; CS high for 4+1 cycles between frames.
- reset low at +30 mid-frame -> CS high immediately; no sample_valid. After release, a fresh start gives a correct sample.
- CLK_DIV=1 build -> sample_valid at +35; data correct.
